// File: rtl/ir_err_calc.sv
// ir_err_calc: IR line-sensor scan sequencer.
// Settles emitters, runs 8 A2D conversions, weights them into a saturated error.
module ir_err_calc #(
  parameter int SETTLE_CYC = 4096,
  parameter int PERIOD_CYC = 65536
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        go,
  input  logic        cnv_cmplt,
  input  logic [11:0] res,
  output logic        IR_en,
  output logic [2:0]  chnnl,
  output logic        strt_cnv,
  output logic [15:0] error,
  output logic        err_vld
);

  localparam int MAXC = (SETTLE_CYC > PERIOD_CYC) ?
                        SETTLE_CYC : PERIOD_CYC;
  localparam int CW = $clog2(MAXC) + 1;
  localparam logic [CW-1:0] SET_LAST = CW'(SETTLE_CYC - 1);
  localparam logic [CW-1:0] PER_LAST = CW'(PERIOD_CYC - 1);

  typedef enum logic [2:0] {
    IDLE, SETTLE, CNV, WAIT, PERIOD
  } state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2:0]         idx_q, idx_d;
  logic signed [16:0] acc_q, acc_d;
  logic [2:0]         chnnl_q, chnnl_d;
  logic               strt_q, strt_d;
  logic               ir_q, ir_d;
  logic [15:0]        err_q, err_d;
  logic               vld_q, vld_d;

  logic [16:0]        mag;
  logic signed [16:0] term;
  logic signed [16:0] sum;
  logic [15:0]        sat;

  // conversion order: index -> A2D channel
  function automatic logic [2:0] ch_of(input logic [2:0] i);
    logic [2:0] c;
    unique case (i)
      3'd0: c = 3'd1;
      3'd1: c = 3'd0;
      3'd2: c = 3'd4;
      3'd3: c = 3'd2;
      3'd4: c = 3'd3;
      3'd5: c = 3'd7;
      3'd6: c = 3'd6;
      default: c = 3'd5;
    endcase
    return c;
  endfunction

  // odd indices subtract; weight doubles every pair of indices
  always_comb begin
    mag  = 17'(res) << idx_q[2:1];
    term = idx_q[0] ? -$signed(mag) : $signed(mag);
    sum  = acc_q + term;
    if (sum > 17'sd32767)
      sat = 16'h7FFF;
    else if (sum < -17'sd32768)
      sat = 16'h8000;
    else
      sat = sum[15:0];
  end

  // next-state and registered-output decode
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    chnnl_d = chnnl_q;
    strt_d  = 1'b0;
    ir_d    = ir_q;
    err_d   = err_q;
    vld_d   = 1'b0;
    if (state_q != IDLE && !go) begin
      state_d = IDLE;
      ir_d    = 1'b0;
      cnt_d   = '0;
      idx_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (go) begin
            state_d = SETTLE;
            ir_d    = 1'b1;
            cnt_d   = '0;
            idx_d   = '0;
            acc_d   = '0;
            chnnl_d = ch_of(3'd0);
          end
        end
        SETTLE: begin
          if (cnt_q == SET_LAST) begin
            state_d = CNV;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        CNV: begin
          state_d = WAIT;
          strt_d  = 1'b1;
        end
        WAIT: begin
          if (cnv_cmplt) begin
            acc_d = sum;
            if (idx_q == 3'd7) begin
              state_d = PERIOD;
              err_d   = sat;
              vld_d   = 1'b1;
              ir_d    = 1'b0;
              cnt_d   = '0;
              idx_d   = '0;
            end else begin
              state_d = CNV;
              idx_d   = idx_q + 3'd1;
              chnnl_d = ch_of(idx_q + 3'd1);
            end
          end
        end
        PERIOD: begin
          if (cnt_q == PER_LAST) begin
            state_d = SETTLE;
            ir_d    = 1'b1;
            cnt_d   = '0;
            acc_d   = '0;
            chnnl_d = ch_of(3'd0);
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // state and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      acc_q   <= '0;
      chnnl_q <= '0;
      strt_q  <= 1'b0;
      ir_q    <= 1'b0;
      err_q   <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      chnnl_q <= chnnl_d;
      strt_q  <= strt_d;
      ir_q    <= ir_d;
      err_q   <= err_d;
      vld_q   <= vld_d;
    end
  end

  assign IR_en    = ir_q;
  assign chnnl    = chnnl_q;
  assign strt_cnv = strt_q;
  assign error    = err_q;
  assign err_vld  = vld_q;

endmodule
